// File: rtl/two_phase_pkg.sv
// rtl/two_phase_pkg.sv - shared state encoding and timing defaults for the latch controller
package two_phase_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MASTER = 3'd1,
    GAP1   = 3'd2,
    SLAVE  = 3'd3,
    GAP2   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int DEFAULT_PULSE = 2;
  localparam int DEFAULT_GAP   = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_counter.sv
// rtl/phase_counter.sv - loadable down-counter timing the current phase, saturates at zero
module phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; decrement stops at zero so the count never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/two_phase_latch_ctrl.sv
// rtl/two_phase_latch_ctrl.sv - non-overlapping master/slave latch enable sequencer
module two_phase_latch_ctrl
  import two_phase_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PULSE = DEFAULT_PULSE,
  parameter int GAP   = DEFAULT_GAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             en_master,
  output logic             en_slave,
  output logic             load_ack,
  output logic             busy
);

  localparam int CW = $clog2(max_int(PULSE, GAP) + 1);

  state_t        state;
  state_t        state_next;
  logic          cnt_load;
  logic          cnt_dec;
  logic          cnt_zero;
  logic [CW-1:0] cnt_val;

  // Counter holds (remaining cycles - 1) of the current phase
  phase_counter #(.W(CW)) u_phase_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: timed phases advance when the counter has run out
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_req) state_next = MASTER;
      MASTER:  if (cnt_zero) state_next = GAP1;
      GAP1:    if (cnt_zero) state_next = SLAVE;
      SLAVE:   if (cnt_zero) state_next = GAP2;
      GAP2:    if (cnt_zero) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter reloads on every state entry with the length of the phase being entered
  always_comb begin
    cnt_load = (state_next != state);
    cnt_dec  = !cnt_zero;
    case (state_next)
      MASTER, SLAVE: cnt_val = CW'(PULSE - 1);
      GAP1, GAP2:    cnt_val = CW'(GAP - 1);
      default:       cnt_val = '0;
    endcase
  end

  // Outputs registered from the next state so they align with the state they describe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_master <= 1'b0;
      en_slave  <= 1'b0;
      load_ack  <= 1'b0;
      busy      <= 1'b0;
      d_out     <= '0;
    end else begin
      en_master <= (state_next == MASTER);
      en_slave  <= (state_next == SLAVE);
      load_ack  <= (state_next == DONE);
      busy      <= (state_next != IDLE);
      if ((state == IDLE) && load_req) begin
        d_out <= d_in;
      end
    end
  end

endmodule

// File: tb/tb_two_phase_latch_ctrl.sv
// tb/tb_two_phase_latch_ctrl.sv - self-checking bench for two_phase_latch_ctrl
module tb_two_phase_latch_ctrl;

  localparam int P1 = 2;
  localparam int G1 = 1;
  localparam int T1 = 2 * P1 + 2 * G1 + 1;
  localparam int P2 = 3;
  localparam int G2 = 2;
  localparam int T2 = 2 * P2 + 2 * G2 + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_req1 = 1'b0;
  logic [7:0] d_in1 = 8'h00;
  logic [7:0] d_out1;
  logic       em1, es1, ack1, busy1;
  logic       load_req2 = 1'b0;
  logic [7:0] d_in2 = 8'h00;
  logic [7:0] d_out2;
  logic       em2, es2, ack2, busy2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  two_phase_latch_ctrl #(.WIDTH(8), .PULSE(P1), .GAP(G1)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req1), .d_in(d_in1), .d_out(d_out1),
    .en_master(em1), .en_slave(es1), .load_ack(ack1), .busy(busy1)
  );

  two_phase_latch_ctrl #(.WIDTH(8), .PULSE(P2), .GAP(G2)) dut2 (
    .clk(clk), .rst_n(rst_n), .load_req(load_req2), .d_in(d_in2), .d_out(d_out2),
    .en_master(em2), .en_slave(es2), .load_ack(ack2), .busy(busy2)
  );

  // Reference model: a transfer is described only by the cycle it was accepted in
  int         ncyc = 0;
  int         acc1 = -1000;
  int         acc2 = -1000;
  logic [7:0] md1 = 8'h00;
  logic [7:0] md2 = 8'h00;
  int         off1, off2;
  logic [11:0] exp1, exp2, obs1, obs2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncyc <= 0;
      acc1 <= -1000;
      acc2 <= -1000;
      md1  <= 8'h00;
      md2  <= 8'h00;
    end else begin
      ncyc <= ncyc + 1;
      if ((ncyc - acc1 > T1) && load_req1) begin
        acc1 <= ncyc;
        md1  <= d_in1;
      end
      if ((ncyc - acc2 > T2) && load_req2) begin
        acc2 <= ncyc;
        md2  <= d_in2;
      end
    end
  end

  always_comb begin
    off1 = ncyc - acc1;
    off2 = ncyc - acc2;
    exp1 = {md1, (off1 >= 1 && off1 <= P1), (off1 >= P1 + G1 + 1 && off1 <= 2 * P1 + G1),
            (off1 == T1), (off1 >= 1 && off1 <= T1)};
    exp2 = {md2, (off2 >= 1 && off2 <= P2), (off2 >= P2 + G2 + 1 && off2 <= 2 * P2 + G2),
            (off2 == T2), (off2 >= 1 && off2 <= T2)};
    obs1 = {d_out1, em1, es1, ack1, busy1};
    obs2 = {d_out2, em2, es2, ack2, busy2};
  end

  always @(negedge clk) begin
    assert (!(em1 && es1)) else $error("enables overlap on dut");
    assert (!(em2 && es2)) else $error("enables overlap on dut2");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    load_req1 = 1'b0;
    load_req2 = 1'b0;
    d_in1 = 'x;
    d_in2 = 'x;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (obs1 !== 12'h000) begin fails++; $display("FAIL reset_dut obs=%h req=%h", obs1, 12'h000); end
    tests++;
    if (obs2 !== 12'h000) begin fails++; $display("FAIL reset_dut2 obs=%h req=%h", obs2, 12'h000); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (obs1 !== 12'h000) begin fails++; $display("FAIL post_reset_x_din obs=%h req=%h", obs1, 12'h000); end
    d_in1 = 8'h00;
    d_in2 = 8'h00;
  endtask

  task automatic test_nominal();
    logic [11:0] lit;
    d_in1 = 8'hA5;
    load_req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) @(negedge clk);
      d_in1 = 8'($urandom);
      lit = {8'hA5, (c == 1 || c == 2), (c == 4 || c == 5), (c == 7), (c >= 1 && c <= 7)};
      tests++;
      if (obs1 !== lit) begin fails++; $display("FAIL nominal_c%0d obs=%h req=%h", c, obs1, lit); end
      tests++;
      if (obs1 !== exp1) begin fails++; $display("FAIL nominal_model_c%0d obs=%h req=%h", c, obs1, exp1); end
    end
  endtask

  task automatic test_busy_request();
    int em_cnt = 0;
    int ack_cnt = 0;
    d_in1 = 8'hA5;
    load_req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req1 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) @(negedge clk);
      tests++;
      if (obs1 !== exp1) begin fails++; $display("FAIL busy_model_c%0d obs=%h req=%h", c, obs1, exp1); end
      em_cnt += int'(em1);
      ack_cnt += int'(ack1);
      load_req1 = (c == 4);
      d_in1 = (c == 4) ? 8'h3C : 8'h00;
    end
    tests++;
    if (d_out1 !== 8'hA5) begin fails++; $display("FAIL busy_dout obs=%h req=%h", d_out1, 8'hA5); end
    tests++;
    if (em_cnt != 2) begin fails++; $display("FAIL busy_master_cycles obs=%0d req=%0d", em_cnt, 2); end
    tests++;
    if (ack_cnt != 1) begin fails++; $display("FAIL busy_acks obs=%0d req=%0d", ack_cnt, 1); end
  endtask

  task automatic test_held_request();
    load_req1 = 1'b1;
    d_in1 = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      tests++;
      if (obs1 !== exp1) begin fails++; $display("FAIL held_model_c%0d obs=%h req=%h", c, obs1, exp1); end
      if (c <= 20) begin
        tests++;
        if (ack1 !== (c == 7 || c == 15)) begin
          fails++; $display("FAIL held_ack_c%0d obs=%b req=%b", c, ack1, (c == 7 || c == 15));
        end
        tests++;
        if (em1 !== (c == 1 || c == 2 || c == 9 || c == 10 || c == 17 || c == 18)) begin
          fails++; $display("FAIL held_master_c%0d obs=%b", c, em1);
        end
      end
      load_req1 = (c < 20);
      d_in1 = 8'($urandom);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int ack_cnt = 0;
    d_in1 = 8'h5A;
    load_req1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_req1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      tests++;
      if (obs1 !== exp1) begin fails++; $display("FAIL rstmid_model_c%0d obs=%h req=%h", c, obs1, exp1); end
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (obs1 !== 12'h000) begin fails++; $display("FAIL rstmid_async obs=%h req=%h", obs1, 12'h000); end
    @(negedge clk);
    tests++;
    if (obs1 !== 12'h000) begin fails++; $display("FAIL rstmid_held obs=%h req=%h", obs1, 12'h000); end
    v = 8'($urandom);
    rst_n = 1'b1;
    load_req1 = 1'b1;
    d_in1 = v;
    @(negedge clk);
    load_req1 = 1'b0;
    tests++;
    if (obs1 !== {v, 4'b1001}) begin fails++; $display("FAIL rstmid_first_accept obs=%h req=%h", obs1, {v, 4'b1001}); end
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      ack_cnt += int'(ack1);
      tests++;
      if (obs1 !== exp1) begin fails++; $display("FAIL rstmid_model_post_c%0d obs=%h req=%h", c, obs1, exp1); end
    end
    tests++;
    if (ack_cnt != 1) begin fails++; $display("FAIL rstmid_acks obs=%0d req=%0d", ack_cnt, 1); end
  endtask

  task automatic test_random_protocol();
    int ack_obs = 0;
    int ack_exp = 0;
    for (int c = 0; c < 1000; c++) begin
      load_req2 = ($urandom_range(0, 3) == 0);
      d_in2 = 8'($urandom);
      @(negedge clk);
      tests++;
      if (obs2 !== exp2) begin fails++; $display("FAIL rand_model_c%0d obs=%h req=%h", c, obs2, exp2); end
      tests++;
      if (em2 && es2) begin fails++; $display("FAIL rand_overlap_c%0d obs=%b req=%b", c, 1'b1, 1'b0); end
      ack_obs += int'(ack2);
      ack_exp += int'(off2 == 11);
    end
    load_req2 = 1'b0;
    tests++;
    if (ack_obs != ack_exp || ack_exp == 0) begin
      fails++; $display("FAIL rand_ack_count obs=%0d req=%0d", ack_obs, ack_exp);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_busy_request();
    test_held_request();
    test_reset_mid();
    test_random_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
